// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and FSM states shared by the ALU arbiter and its ALU
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // 3'b100 and 3'b111 have no ALU function behind them
    function automatic logic op_unsupported(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - purely combinational W-bit ALU shared by both requesters
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_SLT: result = {{(W-1){1'b0}}, (a < b)};
            OP_SLL: result = a << b[4:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err
);

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic         owner_q, owner_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic         rsp_err_q, rsp_err_d;

    logic         grant0, grant1;
    logic         op_err;
    logic         rsp_done;
    logic [W-1:0] alu_result;
    logic [W-1:0] exec_data;

    // The ALU only ever sees the latched operands, never the live request ports
    alu_share_arbiter_alu #(.W(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

    always_comb begin
        grant0    = req0_valid && (!req1_valid || !prio_q);
        grant1    = req1_valid && !grant0;
        op_err    = op_unsupported(op_q);
        exec_data = op_err ? '0 : alu_result;
        rsp_done  = (state_q == S_RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    end

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant0) begin
                    req0_ready = 1'b1;
                    owner_d    = 1'b0;
                    a_d        = req0_a;
                    b_d        = req0_b;
                    op_d       = req0_op;
                    state_d    = S_EXEC;
                end else if (grant1) begin
                    req1_ready = 1'b1;
                    owner_d    = 1'b1;
                    a_d        = req1_a;
                    b_d        = req1_b;
                    op_d       = req1_op;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = exec_data;
                rsp_zero_d = (exec_data == '0);
                rsp_err_d  = op_err;
                state_d    = S_RESP;
            end
            S_RESP: begin
                // Next arbitration favours whoever was not just served
                if (rsp_done) begin
                    prio_d  = ~owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid = (state_q == S_RESP) && owner_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - vector table plus scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        logic         err;
    } exp_t;

    typedef struct {
        int           port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] data;
        logic         zero;
        logic         err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_zero, rsp_err;

    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   grant_log[$];
    int   cyc = 0;
    int   prev_acc = -1;
    int   last_acc[2];
    logic prev_v0 = 1'b0;
    logic prev_v1 = 1'b0;

    alu_share_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on response handshakes
    always @(negedge clk) begin
        exp_t e;
        int   p;
        cyc++;
        if (rst) begin
            prev_acc = -1;
            prev_v0  = 1'b0;
            prev_v1  = 1'b0;
        end else begin
            check("ready_overlap", {31'd0, req0_ready & req1_ready}, 0);
            check("rsp_valid_overlap", {31'd0, rsp0_valid & rsp1_valid}, 0);
            if (req0_ready || req1_ready) begin
                p = req1_ready ? 1 : 0;
                grant_log.push_back(p);
                if (prev_acc >= 0) begin
                    total++;
                    if (cyc - prev_acc < 3) begin
                        bad++;
                        $display("FAIL accept_spacing actual=%0d required>=3", cyc - prev_acc);
                    end
                end
                prev_acc    = cyc;
                last_acc[p] = cyc;
            end
            if (rsp0_valid && !prev_v0) check("latency0", cyc - last_acc[0], 2);
            if (rsp1_valid && !prev_v1) check("latency1", cyc - last_acc[1], 2);
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) check("unexpected_rsp0", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("rsp0_data", rsp_data, e.data);
                    check("rsp0_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                    check("rsp0_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) check("unexpected_rsp1", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("rsp1_data", rsp_data, e.data);
                    check("rsp1_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                    check("rsp1_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
            prev_v0 = rsp0_valid;
            prev_v1 = rsp1_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input exp_t e);
        int n = 0;
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
            q0.push_back(e);
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
            q1.push_back(e);
        end
        forever begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) break;
            n++;
            if (n > 60) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                check("drain_timeout", 0, 1);
                q0.delete();
                q1.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        q0.delete();
        q1.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_req0_ready"}, {31'd0, req0_ready}, 0);
        check({tag, "_req1_ready"}, {31'd0, req1_ready}, 0);
        check({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 0);
        check({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_zero"}, {31'd0, rsp_zero}, 0);
        check({tag, "_rsp_err"}, {31'd0, rsp_err}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[14];
        int   gi;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        vecs[0]  = '{0, 32'd5,          32'd7,        OP_ADD, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{1, 32'd9,          32'd9,        OP_SUB, 32'd0,          1'b1, 1'b0};
        vecs[2]  = '{0, 32'd3,          32'd5,        OP_SUB, 32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[3]  = '{1, 32'hFFFF_FFFF,  32'd1,        OP_ADD, 32'd0,          1'b1, 1'b0};
        vecs[4]  = '{0, 32'h0000_F0F0,  32'h0000_FF00, OP_AND, 32'h0000_F000, 1'b0, 1'b0};
        vecs[5]  = '{1, 32'h0000_F0F0,  32'h0000_0F0F, OP_OR,  32'h0000_FFFF, 1'b0, 1'b0};
        vecs[6]  = '{0, 32'd2,          32'd3,        OP_SLT, 32'd1,          1'b0, 1'b0};
        vecs[7]  = '{1, 32'd3,          32'd2,        OP_SLT, 32'd0,          1'b1, 1'b0};
        vecs[8]  = '{0, 32'hFFFF_FFFF,  32'd1,        OP_SLT, 32'd0,          1'b1, 1'b0};
        vecs[9]  = '{1, 32'd1,          32'd3,        OP_SLL, 32'd8,          1'b0, 1'b0};
        vecs[10] = '{0, 32'd1,          32'h25,       OP_SLL, 32'd32,         1'b0, 1'b0};
        vecs[11] = '{1, 32'd1,          32'd31,       OP_SLL, 32'h8000_0000,  1'b0, 1'b0};
        vecs[12] = '{0, 32'd3,          32'd4,        3'b111, 32'd0,          1'b1, 1'b1};
        vecs[13] = '{1, 32'd3,          32'd4,        3'b100, 32'd0,          1'b1, 1'b1};

        do_reset(2);
        check_reset_values("reset");

        foreach (vecs[i]) begin
            send(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op,
                 '{vecs[i].data, vecs[i].zero, vecs[i].err});
            drain();
        end

        // Simultaneous requests straight after reset: port 0 first, then port 1
        do_reset(2);
        gi = grant_log.size();
        fork
            send(0, 32'd9, 32'd9, OP_SUB, '{32'd0, 1'b1, 1'b0});
            send(1, 32'd1, 32'd3, OP_SLL, '{32'd8, 1'b0, 1'b0});
        join
        drain();
        check("pair_grant_count", grant_log.size() - gi, 2);
        if (grant_log.size() >= gi + 2) begin
            check("pair_first", grant_log[gi], 0);
            check("pair_second", grant_log[gi+1], 1);
        end

        // Both held valid for six operations: strict alternation
        do_reset(2);
        gi = grant_log.size();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    send(0, i, 32'd10, OP_ADD, '{i + 10, 1'b0, 1'b0});
            end
            begin
                for (int j = 0; j < 3; j++)
                    send(1, 32'd100, j, OP_SUB, '{100 - j, 1'b0, 1'b0});
            end
        join
        drain();
        check("alt_grant_count", grant_log.size() - gi, 6);
        if (grant_log.size() >= gi + 6) begin
            for (int k = 0; k < 6; k++) check("alt_order", grant_log[gi+k], k % 2);
        end

        // Back-pressure on port 1 while port 0 waits
        do_reset(2);
        rsp1_ready = 1'b0;
        fork
            send(1, 32'hFF, 32'h0F, OP_AND, '{32'h0F, 1'b0, 1'b0});
            begin
                repeat (2) @(posedge clk);
                #1;
                send(0, 32'd4, 32'd4, OP_ADD, '{32'd8, 1'b0, 1'b0});
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!rsp1_valid && n < 20);
                check("bp_rsp1_seen", {31'd0, rsp1_valid}, 1);
                for (int k = 0; k < 10; k++) begin
                    check("bp_rsp1_valid", {31'd0, rsp1_valid}, 1);
                    check("bp_rsp_data", rsp_data, 32'h0F);
                    check("bp_rsp_zero", {31'd0, rsp_zero}, 0);
                    check("bp_no_accept", {31'd0, req0_ready | req1_ready}, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                rsp1_ready = 1'b1;
            end
        join
        drain();

        // Reset while the operation is in EXEC: it must vanish without a response
        send(0, 32'd20, 32'd22, OP_ADD, '{32'd42, 1'b0, 1'b0});
        do_reset(1);
        check_reset_values("midreset");
        repeat (4) begin
            @(negedge clk);
            check("midreset_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 0);
        end
        @(posedge clk);
        #1;
        send(1, 32'h7, 32'h8, OP_OR, '{32'hF, 1'b0, 1'b0});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
